// File: rtl/kp_pkg.sv
// Shared types and constants for the keypad scan encoder.
package kp_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_e;
    typedef enum logic [1:0] {NONE, ONE, MULTI} kp_class_e;

    localparam logic [3:0] COL0_STROBE = 4'b1110;
    localparam logic [3:0] COL1_STROBE = 4'b1101;
    localparam logic [3:0] COL2_STROBE = 4'b1011;
    localparam logic [3:0] COL3_STROBE = 4'b0111;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        case (idx)
            2'd0:    col_strobe = COL0_STROBE;
            2'd1:    col_strobe = COL1_STROBE;
            2'd2:    col_strobe = COL2_STROBE;
            default: col_strobe = COL3_STROBE;
        endcase
    endfunction

endpackage

// File: rtl/kp_scan_timer.sv
// Column dwell timer: column index, terminal-count and frame-end pulses, registered 1-cold strobe.
import kp_pkg::*;

module kp_scan_timer #(
    parameter int SCAN_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] col_idx,
    output logic       tc,
    output logic       frame_end,
    output logic [3:0] cols
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    cols_q, cols_d;

    assign tc        = (dwell_q == DW'(SCAN_DIV - 1));
    assign frame_end = tc && (col_idx_q == 2'd3);
    assign col_idx   = col_idx_q;
    assign cols      = cols_q;

    always_comb begin
        dwell_d   = tc ? '0 : dwell_q + 1'b1;
        col_idx_d = tc ? col_idx_q + 2'd1 : col_idx_q;
        // Decoding the next index keeps the strobe one cycle behind TC, aligned to col_idx_q.
        cols_d    = col_strobe(col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q   <= '0;
            col_idx_q <= '0;
            cols_q    <= COL0_STROBE;
        end else begin
            dwell_q   <= dwell_d;
            col_idx_q <= col_idx_d;
            cols_q    <= cols_d;
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner: row synchronizer, per-frame classifier, press/release debounce FSM,
// and VALID/ACK handshake with sticky overrun.
import kp_pkg::*;

module keypad_scan_encoder #(
    parameter int SCAN_DIV = 25000,
    parameter int DEBOUNCE = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROWS,
    output logic [3:0] COLS,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_ACK,
    output logic       OVERRUN
);

    localparam int          CW   = $clog2(DEBOUNCE + 1);
    localparam logic [CW:0] DB_L = (CW + 1)'(DEBOUNCE);

    logic [1:0] col_idx;
    logic       tc, frame_end;

    kp_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk       (CLK),
        .rst       (RST),
        .col_idx   (col_idx),
        .tc        (tc),
        .frame_end (frame_end),
        .cols      (COLS)
    );

    logic [3:0]    rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
    logic [1:0]    acc_lows_q, acc_lows_d;
    logic [3:0]    acc_code_q, acc_code_d;
    kp_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overrun_q, overrun_d;

    logic [2:0]  col_lows, tot;
    logic [1:0]  col_row;
    logic [3:0]  code_now;
    kp_class_e   frame_class;
    logic [CW:0] cnt_inc;
    logic        report;

    always_comb begin
        rows_s1_d = ROWS;
        rows_s2_d = rows_s1_q;

        col_lows = '0;
        col_row  = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!rows_s2_q[r]) begin
                col_lows = col_lows + 3'd1;
                col_row  = 2'(r);
            end
        end
        tot      = {1'b0, acc_lows_q} + col_lows;
        code_now = (col_lows == 3'd1) ? {col_idx, col_row} : acc_code_q;
        if (tot == 3'd0)      frame_class = NONE;
        else if (tot == 3'd1) frame_class = ONE;
        else                  frame_class = MULTI;

        // Low count saturates at 2: anything beyond that is already MULTI.
        acc_lows_d = acc_lows_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            acc_lows_d = '0;
            acc_code_d = '0;
        end else if (tc) begin
            acc_lows_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
            acc_code_d = code_now;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        report  = 1'b0;
        cnt_inc = {1'b0, cnt_q} + 1'b1;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_class == ONE) begin
                        cand_d  = code_now;
                        cnt_d   = CW'(1);
                        state_d = PRESS_DB;
                        if (DEBOUNCE == 1) begin
                            report  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end
                    end
                end
                PRESS_DB: begin
                    if (frame_class == ONE && code_now == cand_q) begin
                        if (cnt_inc == DB_L) begin
                            report  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_inc[CW-1:0];
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frame_class == NONE) begin
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE == 1) ? IDLE : REL_DB;
                        if (DEBOUNCE == 1) cnt_d = '0;
                    end
                end
                REL_DB: begin
                    if (frame_class == NONE) begin
                        if (cnt_inc == DB_L) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_inc[CW-1:0];
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        // A report takes priority over a coincident ACK; the ACK still clears overrun.
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (report) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            overrun_d   = KEY_ACK ? 1'b0 : (overrun_q | key_valid_q);
        end else if (KEY_ACK && key_valid_q) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rows_s1_q   <= '1;
            rows_s2_q   <= '1;
            acc_lows_q  <= '0;
            acc_code_q  <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rows_s1_q   <= rows_s1_d;
            rows_s2_q   <= rows_s2_d;
            acc_lows_q  <= acc_lows_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign KEY_CODE  = key_code_q;
    assign KEY_VALID = key_valid_q;
    assign OVERRUN   = overrun_q;

endmodule
